// File: rtl/pixel_writeback.sv
// Frame-buffer writer: buffers filtered pixels, saturates them to a byte and issues
// one write/done handshake per pixel with a bounded wait for completion.
`timescale 1ns/1ps
module pixel_writeback #(
   parameter int IMG_W   = 320,
   parameter int IMG_H   = 240,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  in_x,
   input  logic [8:0]  in_y,
   input  logic [15:0] in_value,
   input  logic        frame_start,
   input  logic        wb_done,
   output logic        wb_write,
   output logic [17:0] wb_address,
   output logic [7:0]  wb_data,
   output logic        busy,
   output logic [17:0] pixels_written,
   output logic        timeout_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE} state_t;

   logic [25:0] mem_q [DEPTH];
   logic [PW:0] wr_ptr_q, rd_ptr_q;
   state_t      state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [17:0] address_q, pixels_q;
   logic [7:0]  data_q, sat_byte;
   logic        err_q, fifo_full, fifo_empty, in_range, push, pop, pw_inc, to_set;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign in_ready   = !fifo_full;
   assign in_range   = ({1'b0, in_x} < 10'(IMG_W)) && ({1'b0, in_y} < 10'(IMG_H));
   // Off-screen pixels are still handshaken so the filter never stalls on them.
   assign push       = in_valid && in_ready && in_range;

   always_comb begin
      sat_byte = in_value[7:0];
      if (in_value[15])
         sat_byte = 8'h00;
      else if (|in_value[14:8])
         sat_byte = 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[PW-1:0]] <= {in_y, in_x, sat_byte};
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pop     = 1'b0;
      pw_inc  = 1'b0;
      to_set  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            timer_d = '0;
            // Never raise a request while the controller still shows done.
            if (!fifo_empty && !wb_done) begin
               pop     = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            timer_d = timer_q + 1'b1;
            if (wb_done) begin
               pw_inc  = 1'b1;
               state_d = S_RELEASE;
            end else if (timer_q == TW'(TIMEOUT)) begin
               to_set  = 1'b1;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            timer_d = '0;
            if (!wb_done)
               state_d = S_IDLE;
         end
         default: begin
            timer_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         address_q <= '0;
         data_q    <= '0;
         pixels_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            {address_q, data_q} <= mem_q[rd_ptr_q[PW-1:0]];
         end
         if (frame_start)
            pixels_q <= '0;
         else if (pw_inc)
            pixels_q <= pixels_q + 1'b1;
         if (frame_start)
            err_q <= 1'b0;
         else if (to_set)
            err_q <= 1'b1;
      end
   end

   assign wb_write       = (state_q == S_WRITE);
   assign wb_address     = address_q;
   assign wb_data        = data_q;
   assign busy           = !fifo_empty || (state_q != S_IDLE);
   assign pixels_written = pixels_q;
   assign timeout_err    = err_q;

endmodule

// File: tb/tb_pixel_writeback.sv
// Directed bench for pixel_writeback: scoreboard of expected writes checked at each
// wb_write rise, plus a frame-buffer responder returning done after a set delay.
`timescale 1ns/1ps
module tb_pixel_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_x, in_y;
   logic [15:0] in_value;
   logic        frame_start;
   logic        wb_done;
   logic        wb_write;
   logic [17:0] wb_address;
   logic [7:0]  wb_data;
   logic        busy;
   logic [17:0] pixels_written;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;
   logic [25:0] sb[$];
   int done_delay = 5;
   int hi_cnt = 0;
   int last_hi_len = 0;
   int rises = 0;

   pixel_writeback dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_value(in_value),
      .frame_start(frame_start), .wb_done(wb_done),
      .wb_write(wb_write), .wb_address(wb_address), .wb_data(wb_data),
      .busy(busy), .pixels_written(pixels_written), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-buffer model: done after done_delay high cycles (0 = never), cleared one
   // cycle after the request falls.
   initial begin
      logic [25:0] exp;
      wb_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            wb_done = 1'b0;
            hi_cnt  = 0;
         end else if (wb_write) begin
            hi_cnt++;
            if (hi_cnt == 1) begin
               rises++;
               chk(32'(wb_done), 32'd0, "rise_while_done");
               chk(32'(sb.size() > 0), 32'd1, "write_expected");
               if (sb.size() > 0) begin
                  exp = sb.pop_front();
                  chk(32'(wb_address), 32'(exp[25:8]), "wb_address");
                  chk(32'(wb_data), 32'(exp[7:0]), "wb_data");
               end
            end
            if (done_delay != 0 && hi_cnt >= done_delay)
               wb_done = 1'b1;
         end else if (hi_cnt != 0) begin
            last_hi_len = hi_cnt;
            hi_cnt      = 0;
         end else begin
            wb_done = 1'b0;
         end
      end
   end

   task automatic push(input int x, input int y, input int v);
      int n = 0;
      int b;
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = 9'(x);
      in_y     = 9'(y);
      in_value = 16'(v);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(32'(in_ready), 32'd1, "push_ready");
      b = (v < 0) ? 0 : (v > 255) ? 255 : v;
      if (x < 320 && y < 240)
         sb.push_back({18'(y * 512 + x), 8'(b)});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy || wb_done) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(32'(busy), 32'd0, "idle_timeout");
   endtask

   initial begin
      int acc;
      int r0;
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      in_value = '0;
      frame_start = 1'b0;
      #12;
      chk(32'(wb_write), 32'd0, "rst_wb_write");
      chk(32'(in_ready), 32'd1, "rst_in_ready");
      chk(32'(busy), 32'd0, "rst_busy");
      chk(32'(pixels_written), 32'd0, "rst_pixels");
      chk(32'(timeout_err), 32'd0, "rst_timeout");
      chk(32'({wb_address, wb_data}), 32'd0, "rst_addr_data");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single pixel, done 5 cycles after the request rises
      done_delay = 5;
      push(10, 5, 100);
      @(negedge clk);
      chk(32'(wb_write), 32'd0, "lat_edge1");
      @(negedge clk);
      chk(32'(wb_write), 32'd1, "lat_edge2");
      chk(32'(wb_address), 32'h00A0A, "t1_address");
      chk(32'(wb_data), 32'h64, "t1_data");
      wait_idle(200);
      chk(32'(last_hi_len), 32'd5, "t1_held_until_done");
      chk(32'(pixels_written), 32'd1, "t1_pixels");

      // 2: saturation
      push(1, 2, -7);
      push(2, 2, 300);
      push(3, 2, 255);
      wait_idle(200);
      chk(32'(pixels_written), 32'd4, "t2_pixels");

      // 3: off-screen pixels dropped
      r0 = rises;
      push(320, 0, 50);
      push(0, 240, 50);
      wait_idle(200);
      chk(32'(rises), 32'(r0), "t3_no_write");
      chk(32'(pixels_written), 32'd4, "t3_pixels");

      // 5: timeout after 64 high cycles, then next pixel issues, frame_start clears
      done_delay = 0;
      push(1, 1, 42);
      wait_idle(300);
      chk(32'(last_hi_len), 32'd64, "t5_high_cycles");
      chk(32'(timeout_err), 32'd1, "t5_timeout_err");
      chk(32'(pixels_written), 32'd4, "t5_not_counted");
      done_delay = 3;
      push(2, 1, 43);
      wait_idle(300);
      chk(32'(pixels_written), 32'd5, "t5_next_pixel");
      chk(32'(timeout_err), 32'd1, "t5_sticky");
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk(32'(timeout_err), 32'd0, "t5_err_cleared");
      chk(32'(pixels_written), 32'd0, "t5_pixels_cleared");

      // 4: back-pressure with done withheld
      done_delay = 0;
      acc = 0;
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_x     = 9'(20 + acc);
         in_y     = 9'd7;
         in_value = 16'(acc * 10);
         if (in_ready) begin
            sb.push_back({18'(7 * 512 + 20 + acc), 8'(acc * 10)});
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk(32'(acc), 32'd5, "t4_accepted");
      chk(32'(in_ready), 32'd0, "t4_full");
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(32'(in_ready), 32'd1, "t4_ready_again");
      chk(32'(wb_write), 32'd1, "t4_ready_with_pop");
      chk(32'(timeout_err), 32'd1, "t4_timeout_err");
      done_delay = 4;
      wait_idle(2000);
      chk(32'(pixels_written), 32'd4, "t4_pixels");

      // 6: asynchronous reset mid-write
      done_delay = 0;
      push(3, 3, 9);
      push(4, 4, 9);
      n = 0;
      while (!wb_write && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(32'(wb_write), 32'd1, "t6_in_write");
      @(negedge clk);
      r0 = rises;
      rst_n = 1'b0;
      #1;
      chk(32'(wb_write), 32'd0, "t6_async_drop");
      chk(32'(busy), 32'd0, "t6_busy_reset");
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      done_delay = 3;
      repeat (100) @(negedge clk);
      chk(32'(rises), 32'(r0), "t6_no_stale_write");
      chk(32'(busy), 32'd0, "t6_busy");
      chk(32'(in_ready), 32'd1, "t6_in_ready");
      chk(32'(pixels_written), 32'd0, "t6_pixels");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
